// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the digit-serial subtractor.
// FSM encoding, default geometry and the digit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 1;

    // Counter must hold 0..WIDTH/DIGIT-1; never let it collapse to zero bits.
    function automatic int cnt_width(input int width, input int digit);
        int w;
        w = $clog2(width / digit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple full-subtractor: {bo, d} = x - y - bi.
// This is the single arithmetic cell the serial subtractor reuses every cycle.
module sub_digit
    import serial_sub_pkg::*;
#(
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] borrow;

    assign borrow[0] = bi;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign d[gi]          = x[gi] ^ y[gi] ^ borrow[gi];
        // Borrow when x<y outright, or when x==y and a borrow arrives from below.
        assign borrow[gi + 1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & borrow[gi]);
    end

    assign bo = borrow[DIGIT];

endmodule

// File: rtl/serial_sub16.sv
// Digit-serial subtractor: diff = a - b - b_in over WIDTH/DIGIT cycles with start/busy/done.
// Optional signed-overflow output is enabled with the SERIAL_SUB_OVF_EN macro.
module serial_sub16
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              N    = WIDTH / DIGIT;
    localparam int              CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             b_out_reg;
    logic [CW-1:0]    cnt_reg;
    logic             accept;
    logic             last_digit;
    logic [DIGIT-1:0] d_digit;
    logic             bo_digit;

    sub_digit #(
        .DIGIT(DIGIT)
    ) u_cell (
        .x (a_reg[DIGIT-1:0]),
        .y (b_reg[DIGIT-1:0]),
        .bi(borrow_reg),
        .d (d_digit),
        .bo(bo_digit)
    );

    assign last_digit = (cnt_reg == LAST);

    // DONE is not busy, so a new request can chain straight into RUN.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            b_out_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg      <= a;
                b_reg      <= b;
                borrow_reg <= b_in;
                cnt_reg    <= '0;
            end else if (state_reg == RUN) begin
                // Operands drain LSB-first; result digits enter at the top and
                // land in their final positions after N shifts.
                a_reg      <= a_reg >> DIGIT;
                b_reg      <= b_reg >> DIGIT;
                diff_reg   <= {d_digit, diff_reg[WIDTH-1:DIGIT]};
                borrow_reg <= bo_digit;
                cnt_reg    <= cnt_reg + CW'(1);
                if (last_digit) begin
                    b_out_reg <= bo_digit;
                end
            end
        end
    end

    assign diff  = diff_reg;
    assign b_out = b_out_reg;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;

    // Operand sign bits are shifted out during RUN, so keep copies for the overflow test.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb_reg <= a[WIDTH-1];
                b_msb_reg <= b[WIDTH-1];
            end else if (state_reg == RUN && last_digit) begin
                ovf_reg <= (a_msb_reg != b_msb_reg) && (d_digit[DIGIT-1] != a_msb_reg);
            end
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_sub16.sv
// Scoreboard bench for serial_sub16: three instances (DIGIT=1,2,4) share operands.
// Stimulus pushes expected results; per-instance monitors pop and compare on done.
module tb_serial_sub16;

    typedef struct {
        logic [15:0] diff;
        logic        bo;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic [15:0] a_s = '0;
    logic [15:0] b_s = '0;
    logic        bin_s = 1'b0;
    logic        busy_v [3];
    logic        done_v [3];
    logic [15:0] diff_v [3];
    logic        bo_v [3];
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf_v [3];
`endif

    exp_t        exp_q [3][$];
    logic [15:0] last_diff [3];
    logic        last_bo [3];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int n_of(input int d);
        return 16 >> d;
    endfunction

    // Reference: plain integer arithmetic on the unsigned operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bi, input int due);
        exp_t e;
        int   r;
        r      = int'(a) - int'(b) - int'(bi);
        e.diff = 16'(r);
        e.bo   = (r < 0);
        e.ovf  = (a[15] != b[15]) && (e.diff[15] != a[15]);
        e.due  = due;
        return e;
    endfunction

    task automatic check_done(input int d);
        exp_t e;
        checks++;
        if (exp_q[d].size() == 0) begin
            errors++;
            $display("FAIL unexpected_done dut%0d cyc=%0d diff=%h", d, cyc, diff_v[d]);
            return;
        end
        e = exp_q[d].pop_front();
        $display("txn dut%0d digit=%0d diff=%h b_out=%b cyc=%0d", d, 1 << d, diff_v[d], bo_v[d], cyc);
        if (diff_v[d] !== e.diff || bo_v[d] !== e.bo || cyc != e.due) begin
            errors++;
            $display("FAIL result dut%0d got diff=%h b_out=%b cyc=%0d want diff=%h b_out=%b cyc=%0d",
                     d, diff_v[d], bo_v[d], cyc, e.diff, e.bo, e.due);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf_v[d] !== e.ovf) begin
            errors++;
            $display("FAIL ovf dut%0d got %b want %b", d, ovf_v[d], e.ovf);
        end
`endif
        last_diff[d] = e.diff;
        last_bo[d]   = e.bo;
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        serial_sub16 #(
            .WIDTH(16),
            .DIGIT(1 << gi)
        ) dut (
            .clk  (clk),
            .rst  (rst),
            .start(start_v[gi]),
            .a    (a_s),
            .b    (b_s),
            .b_in (bin_s),
            .busy (busy_v[gi]),
            .done (done_v[gi]),
            .diff (diff_v[gi]),
            .b_out(bo_v[gi])
`ifdef SERIAL_SUB_OVF_EN
            ,
            .ovf  (ovf_v[gi])
`endif
        );

        always @(negedge clk) begin
            if (done_v[gi] !== 1'b0) check_done(gi);
        end
    end

    // Returns at a negedge once every instance is idle and drained; also checks result hold.
    task automatic wait_idle();
        bit idle;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            idle = 1'b1;
            for (int d = 0; d < 3; d++) begin
                if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || exp_q[d].size() != 0) idle = 1'b0;
            end
            if (idle) begin
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (diff_v[d] !== last_diff[d] || bo_v[d] !== last_bo[d]) begin
                        errors++;
                        $display("FAIL hold dut%0d got diff=%h b_out=%b want diff=%h b_out=%b",
                                 d, diff_v[d], bo_v[d], last_diff[d], last_bo[d]);
                    end
                end
                return;
            end
        end
        errors++;
        $display("FAIL idle_timeout cyc=%0d got busy not idle want idle", cyc);
        for (int d = 0; d < 3; d++) exp_q[d].delete();
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bi);
        wait_idle();
        a_s   = a;
        b_s   = b;
        bin_s = bi;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b1;
            exp_q[d].push_back(model(a, b, bi, cyc + 1 + n_of(d)));
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
    endtask

    logic [15:0] dir_a [4] = '{16'h0005, 16'h0000, 16'h1234, 16'h8000};
    logic [15:0] dir_b [4] = '{16'h0003, 16'h0001, 16'h1233, 16'h0001};
    logic        dir_k [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        for (int d = 0; d < 3; d++) begin
            start_v[d]   = 1'b0;
            last_diff[d] = '0;
            last_bo[d]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || diff_v[d] !== 16'h0 || bo_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d got busy=%b done=%b diff=%h b_out=%b want 0 0 0000 0",
                         d, busy_v[d], done_v[d], diff_v[d], bo_v[d]);
            end
        end
        rst = 1'b0;

        for (int i = 0; i < 4; i++) issue(dir_a[i], dir_b[i], dir_k[i]);

        // A request arriving mid-RUN must be dropped without touching latched operands.
        issue(16'h00FF, 16'h000F, 1'b0);
        @(negedge clk);
        a_s = 16'hFFFF;
        b_s = 16'hFFFF;
        for (int d = 0; d < 3; d++) start_v[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;

        // Abort mid-RUN with reset: no done, outputs cleared.
        issue(16'h4321, 16'h1234, 1'b1);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) exp_q[d].delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || diff_v[d] !== 16'h0 || bo_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort dut%0d got busy=%b done=%b diff=%h b_out=%b want 0 0 0000 0",
                         d, busy_v[d], done_v[d], diff_v[d], bo_v[d]);
            end
            last_diff[d] = '0;
            last_bo[d]   = 1'b0;
        end
        repeat (20) @(negedge clk);

        // Back-to-back: start held high, each instance accepts every N+1 cycles.
        for (int d = 0; d < 3; d++) begin
            wait_idle();
            start_v[d] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                a_s   = 16'($urandom);
                b_s   = 16'($urandom);
                bin_s = 1'($urandom);
                exp_q[d].push_back(model(a_s, b_s, bin_s, cyc + 1 + n_of(d)));
                if (k < 2) repeat (n_of(d) + 1) @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            start_v[d] = 1'b0;
        end

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++)
                    issue(16'(i), 16'(j), 1'(k));

        for (int r = 0; r < 150; r++) issue(16'($urandom), 16'($urandom), 1'($urandom));

        wait_idle();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin
                errors++;
                $display("FAIL drained dut%0d got %0d pending want 0", d, exp_q[d].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub16.md
# serial_sub16

Multi-cycle digit-serial subtractor: computes `a - b - b_in` over `WIDTH/DIGIT` clock cycles and returns the difference and borrow-out. It is the inverse-direction counterpart of the 16-bit ripple full adder in the arithmetic library. A start/busy/done handshake lets a controller or bench issue one operation at a time. The design trades latency for a single `DIGIT`-bit subtract cell.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width in bits.
- `DIGIT`, 1, bits processed per cycle; legal values 1, 2, 4; must divide `WIDTH`.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `a`  in  `WIDTH`  minuend; latched on an accepted start.
- `b`  in  `WIDTH`  subtrahend; latched on an accepted start.
- `b_in`  in  1  borrow-in; latched on an accepted start.
- `busy`  out  1  high while the operation is running.
- `done`  out  1  one-cycle pulse; results are valid on this cycle.
- `diff`  out  `WIDTH`  result, `(a - b - b_in) mod 2^WIDTH`.
- `b_out`  out  1  borrow-out; 1 iff `a < b + b_in`, unsigned.
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, `start`=1: latch `a`, `b`, `b_in` into shift registers; clear the digit counter; go to RUN.
- IDLE, `start`=0: stay in IDLE.
- RUN, each cycle:
  - Subtract the low `DIGIT` bits of the operands plus the running borrow.
  - Shift the result digit into `diff` from the MSB side.
  - Update the running borrow.
  - Increment the counter.
- RUN to DONE: after `N = WIDTH/DIGIT` RUN cycles.
- DONE: `done`=1 for one cycle; `b_out` = final borrow. Return to IDLE next cycle.
- Start acceptance: `start` is accepted in DONE (DONE has `busy`=0) and in IDLE. An accept in DONE goes directly to RUN.
- `start` while `busy`=1 is ignored; latched operands are unaffected.
- Hold behaviour: `diff`, `b_out`, `ovf` hold their last values until the next DONE.
  - During RUN, `diff` holds partial shift contents and is undefined to consumers.
- Arithmetic: unsigned, modulo 2^`WIDTH`. `b_in`=1 with `a`=`b` gives all-ones and `b_out`=1.

## Timing
- Reset (`rst`=1 at an edge) forces: state IDLE, `busy`=0, `done`=0, `diff`=0, `b_out`=0, `ovf`=0, counter=0.
- Reset mid-RUN aborts the operation with no `done` pulse. Reset has priority over `start`.
- Cycle sequence, with start accepted at edge E:
  - `busy`=1 from E until edge E+N.
  - `done`=1 in the cycle after edge E+N.
  - Example: `WIDTH`=16, `DIGIT`=1 gives `done` 17 edges after start. `DIGIT`=4 gives 5 edges.
- Back-to-back: `start` held high in the DONE cycle re-enters RUN at the next edge. This gives one idle-free operation every N+1 cycles.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` port exists.
  - `ovf` = (`a`[MSB] != `b`[MSB]) && (`diff`[MSB] != `a`[MSB]), registered with `diff` at DONE.
  - Reset value 0.
- Undefined: no `ovf` port and no related logic. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg`:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default `WIDTH`/`DIGIT` constants.
  - Counter-width function `$clog2(WIDTH/DIGIT)`.
- Sub-module `sub_digit`: combinational `DIGIT`-bit ripple full-subtractor.
  - Inputs: `x`, `y`, `bi`.
  - Outputs: `d`, `bo`.
  - Instantiated once.

## Test plan
- `a`=0x0005, `b`=0x0003, `b_in`=0 → `diff`=0x0002, `b_out`=0; `done` exactly 17 edges after start (`DIGIT`=1).
- `a`=0x0000, `b`=0x0001, `b_in`=0 → `diff`=0xFFFF, `b_out`=1.
- `a`=0x1234, `b`=0x1233, `b_in`=1 → `diff`=0x0000, `b_out`=0.
- `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `b_out`=0, `ovf`=1 with macro; no `ovf` port without it.
- Start 0x00FF−0x000F, then pulse `start` with 0xFFFF−0xFFFF at RUN cycle 5 → `diff`=0x00F0; second request ignored; exactly one `done`.
- Assert `rst` at RUN cycle 8 → next cycle `busy`=0, `diff`=0x0000, no `done`. Sweep i,j∈0..15, k∈0..1 against `i-j-k` mod 2^16 for `DIGIT`=1,2,4.
